// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction-fetch front end. Owns the fetch PC, issues
//             sequential requests to the instruction cache and buffers
//             completed {pc, instr} pairs in a DEPTH-entry circular FIFO
//             that decode drains through a valid/ready handshake. A
//             redirect from the branch unit flushes the queue and restarts
//             fetch at redirect_pc.
//  Ports    : clock, reset               - clock / synchronous active-high reset
//             icache_ren, icache_addr    - fetch request / address (= fetch PC)
//             icache_stall               - fetched word not valid this cycle
//             instruction_input          - fetched word
//             redirect, redirect_pc      - flush and restart fetch
//             deq_ready / deq_valid      - decode handshake
//             deq_instr, deq_pc          - head entry
//             count, full, empty         - occupancy
//  Options  : FETCHQ_BYPASS_EN - when defined, a fetch completing into an
//             empty queue is presented on the deq outputs in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int                 IADDR_W  = 32,
    parameter int                 IWORD_W  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [IADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         icache_ren,
    output logic [IADDR_W-1:0]           icache_addr,
    input  logic                         icache_stall,
    input  logic [IWORD_W-1:0]           instruction_input,
    input  logic                         redirect,
    input  logic [IADDR_W-1:0]           redirect_pc,
    input  logic                         deq_ready,
    output logic                         deq_valid,
    output logic [IWORD_W-1:0]           deq_instr,
    output logic [IADDR_W-1:0]           deq_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = $clog2(DEPTH+1);
    localparam logic [IADDR_W-1:0] c_step  = IADDR_W'(IWORD_W / 8);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [c_ptr_w-1:0] head_q, head_d;
    logic [c_ptr_w-1:0] tail_q, tail_d;
    logic [c_cnt_w-1:0] count_q, count_d;

    // Queue storage; contents are intentionally not reset.
    logic [IADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [IWORD_W-1:0] instr_mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_fetch_done;
    logic w_bypass_hit;   // fetch completing into an empty queue is shown on deq_*
    logic w_bypass_take;  // ... and decode consumes it, so it is never stored
    logic w_push;
    logic w_pop;

    always_comb begin
        w_full       = (count_q == c_depth);
        w_empty      = (count_q == '0);
        // Request depends only on registered occupancy, so a pop re-opens
        // fetch one cycle later with no path from deq_ready.
        icache_ren   = ~reset & ~w_full;
        w_fetch_done = icache_ren & ~icache_stall & ~redirect;
`ifdef FETCHQ_BYPASS_EN
        w_bypass_hit = w_fetch_done & w_empty;
`else
        w_bypass_hit = 1'b0;
`endif
        w_bypass_take = w_bypass_hit & deq_ready;
        w_push        = w_fetch_done & ~w_bypass_take;
        // Popping an empty queue is a no-op; a redirect suppresses the pop.
        w_pop         = deq_ready & ~w_empty & ~redirect;
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (w_fetch_done) begin
                fetch_pc_d = fetch_pc_q + c_step;
            end
            if (w_push) begin
                tail_d = tail_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                head_d = head_q + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_cnt_w'(1);
                2'b01:   count_d = count_q - c_cnt_w'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // w_push already excludes reset (via icache_ren) and redirect.
    always_ff @(posedge clock) begin
        if (w_push) begin
            pc_mem_q[tail_q]    <= fetch_pc_q;
            instr_mem_q[tail_q] <= instruction_input;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        icache_addr = fetch_pc_q;
        deq_valid   = (~w_empty | w_bypass_hit) & ~redirect;
        if (w_bypass_hit) begin
            deq_instr = instruction_input;
            deq_pc    = fetch_pc_q;
        end else begin
            deq_instr = instr_mem_q[head_q];
            deq_pc    = pc_mem_q[head_q];
        end
        count = count_q;
        full  = w_full;
        empty = w_empty;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue (DEPTH=4, 32-bit). Every
//             fetched word the bench supplies is pushed to a scoreboard
//             queue and popped/compared when decode takes it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        icache_ren;
    logic [31:0] icache_addr;
    logic        icache_stall;
    logic [31:0] instruction_input;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    fetch_queue #(
        .IADDR_W  (32),
        .IWORD_W  (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) u_dut (
        .clock             (clock),
        .reset             (reset),
        .icache_ren        (icache_ren),
        .icache_addr       (icache_addr),
        .icache_stall      (icache_stall),
        .instruction_input (instruction_input),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .deq_ready         (deq_ready),
        .deq_valid         (deq_valid),
        .deq_instr         (deq_instr),
        .deq_pc            (deq_pc),
        .count             (count),
        .full              (full),
        .empty             (empty)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard of {pc, instr} in enqueue order, plus reference fetch PC.
    logic [63:0] sb[$];
    logic [31:0] m_pc;
    logic [15:0] seq = 16'h0;

    // One clock cycle: drive at negedge, check 1 ns later, then update the
    // reference for the coming rising edge.
    task automatic step(input logic rst, input logic stall, input logic rdy,
                        input logic rdr, input logic [31:0] rpc);
        logic        e_ren;
        logic        e_fetch;
        logic        e_valid;
        logic        byp;
        logic [31:0] word;
        logic [63:0] head;
        @(negedge clock);
        seq++;
        word              = {seq, m_pc[15:0]};
        reset             = rst;
        icache_stall      = stall;
        deq_ready         = rdy;
        redirect          = rdr;
        redirect_pc       = rpc;
        instruction_input = word;
        #1;
        e_ren   = ~rst && (sb.size() < DEPTH);
        e_fetch = e_ren && !stall && !rdr;
        byp     = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp     = e_fetch && (sb.size() == 0);
`endif
        e_valid = ((sb.size() != 0) || byp) && !rdr;
        chk("ren",   64'(icache_ren), 64'(e_ren));
        chk("count", 64'(count), 64'(sb.size()));
        chk("full",  64'(full),  64'(sb.size() == DEPTH));
        chk("empty", 64'(empty), 64'(sb.size() == 0));
        if (!rst) begin
            chk("addr",      64'(icache_addr), 64'(m_pc));
            chk("deq_valid", 64'(deq_valid),   64'(e_valid));
        end
        if (e_valid) begin
            head = byp ? {m_pc, word} : sb[0];
            chk("deq_pc",    64'(deq_pc),    64'(head[63:32]));
            chk("deq_instr", 64'(deq_instr), 64'(head[31:0]));
        end
        // Reference update for the edge.
        if (rst) begin
            sb.delete();
            m_pc = 32'h0;
        end else if (rdr) begin
            sb.delete();
            m_pc = rpc;
        end else begin
            if (rdy && e_valid && !byp) void'(sb.pop_front());
            if (e_fetch && !(byp && rdy)) sb.push_back({m_pc, word});
            if (e_fetch) m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        reset = 1'b1; icache_stall = 1'b0; deq_ready = 1'b0; redirect = 1'b0;
        redirect_pc = '0; instruction_input = '0; m_pc = 32'h0;

        // Reset held: ren low, queue empty.
        repeat (2) step(1, 0, 0, 0, 0);
        @(negedge clock); #1;
        chk("rst_ren_low", 64'(icache_ren), 64'(0));
        // Streaming: stall=0, ready=1.
        repeat (10) step(0, 0, 1, 0, 0);
        // Back-pressure: fill to full, hold, then drain.
        repeat (7) step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        // Miss for 5 cycles then resume.
        repeat (5) step(0, 1, 0, 0, 0);
        repeat (2) step(0, 0, 1, 0, 0);
        // Build occupancy, redirect with a hit completing in the same cycle.
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h100);
        repeat (3) step(0, 0, 0, 0, 0);
        // Address wrap.
        step(0, 0, 1, 1, 32'hFFFF_FFFC);
        repeat (4) step(0, 0, 1, 0, 0);
        // Reset in the middle of a miss.
        step(0, 1, 0, 1, 32'h200);
        repeat (2) step(0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(0, ($urandom_range(0, 9) < 3), $urandom_range(0, 1),
                 ($urandom_range(0, 19) == 0), {$urandom_range(0, 16'hFFFF), 16'h0} | 32'(4 * $urandom_range(0, 3)));
        end
        // Final drain.
        repeat (8) step(0, 1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
